// File: rtl/port_timer_pkg.sv
// Shared register map and CTRL bit layout for the port-mapped countdown timer.
package port_timer_pkg;
  localparam logic [7:0] OFF_CTRL     = 8'd0;
  localparam logic [7:0] OFF_STATUS   = 8'd1;
  localparam logic [7:0] OFF_RELOAD   = 8'd2;
  localparam logic [7:0] OFF_COUNT    = 8'd3;
  localparam logic [7:0] OFF_PRESCALE = 8'd4;
  localparam logic [7:0] NUM_REGS     = 8'd5;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;
  localparam int CTRL_W    = 3;
endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler: emits a one-cycle tick every limit+1 enabled clocks.
module timer_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clear,
  input  logic [7:0] limit,
  output logic       tick
);
  logic [7:0] cnt_q, cnt_d;

  // >= so that lowering limit below the running count wraps at once instead of rolling over 255
  assign tick = en & (cnt_q >= limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)     cnt_d = 8'd0;
    else if (tick) cnt_d = 8'd0;
    else if (en)   cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 8'd0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/port_timer.sv
// Port-bus countdown timer with reload, auto-repeat and a level interrupt on expiry.
module port_timer
  import port_timer_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic [7:0] port_adr_i,
  input  logic       port_cyc_i,
  input  logic       port_stb_i,
  input  logic       port_we_i,
  input  logic [7:0] port_dat_i,
  output logic [7:0] port_dat_o,
  output logic       port_ack_o,
  output logic       int_req_o,
  input  logic       int_ack_i
);
  logic              ack_q, ack_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              exp_q, exp_d;
  logic [7:0]        reload_q, reload_d;
  logic [7:0]        count_q, count_d;
  logic [7:0]        prescale_q, prescale_d;

  logic [7:0] off;
  logic       sel, wr, tick, expire, presc_clr;
  logic       wr_ctrl, wr_status, wr_reload, wr_prescale;
  logic [7:0] rd_data;

  assign off = port_adr_i - BASE_ADDR;
  assign sel = port_cyc_i & port_stb_i & (off < NUM_REGS);
  assign wr  = ack_q & sel & port_we_i;

  assign wr_ctrl     = wr & (off == OFF_CTRL);
  assign wr_status   = wr & (off == OFF_STATUS);
  assign wr_reload   = wr & (off == OFF_RELOAD);
  assign wr_prescale = wr & (off == OFF_PRESCALE);

  assign expire    = tick & (count_q == 8'd0);
  assign presc_clr = wr_reload | (wr_ctrl & port_dat_i[CTRL_EN] & ~ctrl_q[CTRL_EN]);

  timer_prescaler u_presc (
    .clk   (clk),
    .rst   (rst),
    .en    (ctrl_q[CTRL_EN] & cen),
    .clear (presc_clr),
    .limit (prescale_q),
    .tick  (tick)
  );

  always_comb begin
    ack_d      = sel & ~ack_q;
    ctrl_d     = ctrl_q;
    exp_d      = exp_q;
    reload_d   = reload_q;
    count_d    = count_q;
    prescale_d = prescale_q;

    if (expire & ~ctrl_q[CTRL_AUTO]) ctrl_d[CTRL_EN] = 1'b0;
    if (wr_ctrl)                     ctrl_d = port_dat_i[CTRL_W-1:0];

    // set beats clear so a coincident acknowledge cannot lose an expiry
    if (int_ack_i | (wr_status & port_dat_i[0])) exp_d = 1'b0;
    if (expire)                                  exp_d = 1'b1;

    if (tick) begin
      if (count_q != 8'd0)        count_d = count_q - 8'd1;
      else if (ctrl_q[CTRL_AUTO]) count_d = reload_q;
    end
    if (wr_reload) begin
      reload_d = port_dat_i;
      count_d  = port_dat_i;
    end
    if (wr_prescale) prescale_d = port_dat_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q      <= 1'b0;
      ctrl_q     <= '0;
      exp_q      <= 1'b0;
      reload_q   <= 8'd0;
      count_q    <= 8'd0;
      prescale_q <= 8'd0;
    end else begin
      ack_q      <= ack_d;
      ctrl_q     <= ctrl_d;
      exp_q      <= exp_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (off)
      OFF_CTRL:     rd_data = {{(8-CTRL_W){1'b0}}, ctrl_q};
      OFF_STATUS:   rd_data = {7'd0, exp_q};
      OFF_RELOAD:   rd_data = reload_q;
      OFF_COUNT:    rd_data = count_q;
      OFF_PRESCALE: rd_data = prescale_q;
      default:      rd_data = 8'h00;
    endcase
  end

  // zero outside the ack cycle so several peripherals can share an OR-ed read bus
  assign port_dat_o = ack_q ? rd_data : 8'h00;
  assign port_ack_o = ack_q;
  assign int_req_o  = exp_q & ctrl_q[CTRL_IE];
endmodule

// File: tb/tb_port_timer.sv
// Directed bench for port_timer: register access, countdown/expiry timing, reset.
module tb_port_timer;
  localparam logic [7:0] BASE = 8'h10;

  logic       clk = 1'b0;
  logic       rst, cen;
  logic [7:0] port_adr_i, port_dat_i, port_dat_o;
  logic       port_cyc_i, port_stb_i, port_we_i, port_ack_o;
  logic       int_req_o, int_ack_i;

  int vecs = 0;
  int errs = 0;

  port_timer #(.BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .port_adr_i (port_adr_i),
    .port_cyc_i (port_cyc_i),
    .port_stb_i (port_stb_i),
    .port_we_i  (port_we_i),
    .port_dat_i (port_dat_i),
    .port_dat_o (port_dat_o),
    .port_ack_o (port_ack_o),
    .int_req_o  (int_req_o),
    .int_ack_i  (int_ack_i)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge after the commit edge.
  task automatic bus(input logic we, input logic [7:0] a, input logic [7:0] d,
                     output logic ack, output logic [7:0] q);
    port_cyc_i = 1'b1; port_stb_i = 1'b1; port_we_i = we;
    port_adr_i = a;    port_dat_i = d;
    @(negedge clk);
    ack = port_ack_o; q = port_dat_o;
    @(negedge clk);
    port_cyc_i = 1'b0; port_stb_i = 1'b0; port_we_i = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    logic a; logic [7:0] q;
    vecs++; if (port_ack_o !== 1'b0) begin errs++; $display("FAIL rst_ack got %b want 0", port_ack_o); end
    vecs++; if (port_dat_o !== 8'h00) begin errs++; $display("FAIL rst_dat got %h want 00", port_dat_o); end
    vecs++; if (int_req_o !== 1'b0) begin errs++; $display("FAIL rst_int got %b want 0", int_req_o); end
    rst = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 5; r++) begin
      bus(1'b0, BASE + 8'(r), 8'h00, a, q);
      vecs++;
      if (a !== 1'b1 || q !== 8'h00) begin
        errs++; $display("FAIL rst_reg%0d got ack=%b dat=%h want ack=1 dat=00", r, a, q);
      end
    end
  endtask

  task automatic test_read_ack;
    int acks = 0;
    logic [2:0] seen;
    logic [7:0] d1;
    port_cyc_i = 1'b1; port_stb_i = 1'b1; port_we_i = 1'b0; port_adr_i = BASE;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      seen[c] = port_ack_o;
      if (c == 0) d1 = port_dat_o;
      if (port_ack_o === 1'b1) acks++;
      if (c == 1) begin port_cyc_i = 1'b0; port_stb_i = 1'b0; end
    end
    vecs++; if (acks != 1) begin errs++; $display("FAIL ack_count got %0d want 1", acks); end
    vecs++; if (seen !== 3'b001) begin errs++; $display("FAIL ack_cycle got %b want 001", seen); end
    vecs++; if (d1 !== 8'h00) begin errs++; $display("FAIL ack_data got %h want 00", d1); end
  endtask

  task automatic test_regs;
    logic a; logic [7:0] q;
    bus(1'b1, BASE + 8'd2, 8'h5A, a, q);
    bus(1'b0, BASE + 8'd3, 8'h00, a, q);
    vecs++; if (q !== 8'h5A) begin errs++; $display("FAIL reload_loads_count got %h want 5a", q); end
    bus(1'b1, BASE + 8'd3, 8'h11, a, q);
    vecs++; if (a !== 1'b1) begin errs++; $display("FAIL count_wr_ack got %b want 1", a); end
    bus(1'b0, BASE + 8'd3, 8'h00, a, q);
    vecs++; if (q !== 8'h5A) begin errs++; $display("FAIL count_ro got %h want 5a", q); end
    bus(1'b0, BASE + 8'd2, 8'h00, a, q);
    vecs++; if (q !== 8'h5A) begin errs++; $display("FAIL reload_rd got %h want 5a", q); end
    bus(1'b1, BASE + 8'd0, 8'hF8, a, q);
    bus(1'b0, BASE + 8'd0, 8'h00, a, q);
    vecs++; if (q !== 8'h00) begin errs++; $display("FAIL ctrl_mask got %h want 00", q); end
    bus(1'b1, BASE + 8'd4, 8'hC3, a, q);
    bus(1'b0, BASE + 8'd4, 8'h00, a, q);
    vecs++; if (q !== 8'hC3) begin errs++; $display("FAIL prescale_rd got %h want c3", q); end
  endtask

  task automatic test_expire_auto;
    logic a; logic [7:0] q;
    cen = 1'b1;
    bus(1'b1, BASE + 8'd4, 8'd1, a, q);
    bus(1'b1, BASE + 8'd2, 8'd3, a, q);
    bus(1'b1, BASE + 8'd0, 8'h07, a, q);
    wait_neg(7);
    vecs++; if (int_req_o !== 1'b0) begin errs++; $display("FAIL auto_early got %b want 0", int_req_o); end
    @(negedge clk);
    vecs++; if (int_req_o !== 1'b1) begin errs++; $display("FAIL auto_int got %b want 1", int_req_o); end
    cen = 1'b0;
    bus(1'b0, BASE + 8'd3, 8'h00, a, q);
    vecs++; if (q !== 8'd3) begin errs++; $display("FAIL auto_reload got %h want 03", q); end
    bus(1'b0, BASE + 8'd1, 8'h00, a, q);
    vecs++; if (q !== 8'h01) begin errs++; $display("FAIL auto_status got %h want 01", q); end
    bus(1'b1, BASE + 8'd1, 8'h01, a, q);
    vecs++; if (int_req_o !== 1'b0) begin errs++; $display("FAIL status_w1c got %b want 0", int_req_o); end
    bus(1'b1, BASE + 8'd0, 8'h00, a, q);
  endtask

  task automatic test_oneshot;
    logic a; logic [7:0] q;
    cen = 1'b1;
    bus(1'b1, BASE + 8'd4, 8'd0, a, q);
    bus(1'b1, BASE + 8'd2, 8'd2, a, q);
    bus(1'b1, BASE + 8'd0, 8'h01, a, q);
    wait_neg(3);
    bus(1'b0, BASE + 8'd0, 8'h00, a, q);
    vecs++; if (q !== 8'h00) begin errs++; $display("FAIL oneshot_en got %h want 00", q); end
    bus(1'b0, BASE + 8'd1, 8'h00, a, q);
    vecs++; if (q !== 8'h01) begin errs++; $display("FAIL oneshot_exp got %h want 01", q); end
    wait_neg(4);
    bus(1'b0, BASE + 8'd3, 8'h00, a, q);
    vecs++; if (q !== 8'h00) begin errs++; $display("FAIL oneshot_count got %h want 00", q); end
    vecs++; if (int_req_o !== 1'b0) begin errs++; $display("FAIL oneshot_noie got %b want 0", int_req_o); end
    int_ack_i = 1'b1; @(negedge clk); int_ack_i = 1'b0;
    bus(1'b0, BASE + 8'd1, 8'h00, a, q);
    vecs++; if (q !== 8'h00) begin errs++; $display("FAIL intack_clr got %h want 00", q); end
  endtask

  task automatic test_back_to_back;
    logic a; logic [7:0] q;
    bus(1'b1, BASE + 8'd2, 8'd0, a, q);
    bus(1'b1, BASE + 8'd0, 8'h07, a, q);
    vecs++; if (int_req_o !== 1'b0) begin errs++; $display("FAIL b2b_pre got %b want 0", int_req_o); end
    @(negedge clk);
    vecs++; if (int_req_o !== 1'b1) begin errs++; $display("FAIL b2b_first got %b want 1", int_req_o); end
    int_ack_i = 1'b1;
    @(negedge clk);
    int_ack_i = 1'b0;
    vecs++; if (int_req_o !== 1'b1) begin errs++; $display("FAIL ack_vs_tick got %b want 1", int_req_o); end
    bus(1'b1, BASE + 8'd1, 8'h01, a, q);
    vecs++; if (int_req_o !== 1'b1) begin errs++; $display("FAIL w1c_vs_tick got %b want 1", int_req_o); end
    cen = 1'b0;
    int_ack_i = 1'b1; @(negedge clk); int_ack_i = 1'b0;
    vecs++; if (int_req_o !== 1'b0) begin errs++; $display("FAIL frozen_ack got %b want 0", int_req_o); end
  endtask

  task automatic test_window;
    logic a; logic [7:0] q;
    bus(1'b1, BASE + 8'd5, 8'hFF, a, q);
    vecs++; if (a !== 1'b0 || q !== 8'h00) begin errs++; $display("FAIL win_hi got ack=%b dat=%h want 0/00", a, q); end
    bus(1'b1, 8'h0F, 8'hFF, a, q);
    vecs++; if (a !== 1'b0 || q !== 8'h00) begin errs++; $display("FAIL win_lo got ack=%b dat=%h want 0/00", a, q); end
    bus(1'b0, BASE + 8'd5, 8'h00, a, q);
    vecs++; if (a !== 1'b0 || q !== 8'h00) begin errs++; $display("FAIL win_rd got ack=%b dat=%h want 0/00", a, q); end
    bus(1'b0, BASE + 8'd0, 8'h00, a, q);
    vecs++; if (q !== 8'h07) begin errs++; $display("FAIL win_ctrl got %h want 07", q); end
    bus(1'b0, BASE + 8'd2, 8'h00, a, q);
    vecs++; if (q !== 8'h00) begin errs++; $display("FAIL win_reload got %h want 00", q); end
    bus(1'b0, BASE + 8'd4, 8'h00, a, q);
    vecs++; if (q !== 8'h00) begin errs++; $display("FAIL win_prescale got %h want 00", q); end
  endtask

  task automatic test_reset_mid;
    logic a; logic [7:0] q;
    int n = 0;
    bus(1'b1, BASE + 8'd4, 8'd2, a, q);
    bus(1'b1, BASE + 8'd2, 8'd5, a, q);
    cen = 1'b1;
    while (int_req_o !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    vecs++; if (int_req_o !== 1'b1) begin errs++; $display("FAIL mid_timeout got int=%b want 1", int_req_o); end
    port_cyc_i = 1'b1; port_stb_i = 1'b1; port_we_i = 1'b0; port_adr_i = BASE + 8'd2;
    @(posedge clk); #1;
    vecs++; if (port_ack_o !== 1'b1) begin errs++; $display("FAIL mid_inflight got %b want 1", port_ack_o); end
    rst = 1'b0; #1;
    vecs++;
    if (port_ack_o !== 1'b0 || port_dat_o !== 8'h00 || int_req_o !== 1'b0) begin
      errs++; $display("FAIL mid_async got ack=%b dat=%h int=%b want 0/00/0", port_ack_o, port_dat_o, int_req_o);
    end
    @(negedge clk);
    port_cyc_i = 1'b0; port_stb_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    vecs++; if (port_ack_o !== 1'b0) begin errs++; $display("FAIL mid_noack got %b want 0", port_ack_o); end
    bus(1'b0, BASE + 8'd3, 8'h00, a, q);
    vecs++; if (q !== 8'h00) begin errs++; $display("FAIL mid_count got %h want 00", q); end
    bus(1'b0, BASE + 8'd0, 8'h00, a, q);
    vecs++; if (q !== 8'h00) begin errs++; $display("FAIL mid_ctrl got %h want 00", q); end
  endtask

  initial begin
    rst = 1'b0; cen = 1'b0; int_ack_i = 1'b0;
    port_adr_i = 8'h00; port_dat_i = 8'h00;
    port_cyc_i = 1'b0; port_stb_i = 1'b0; port_we_i = 1'b0;
    wait_neg(2);
    test_reset;
    test_read_ack;
    test_regs;
    test_expire_auto;
    test_oneshot;
    test_back_to_back;
    test_window;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
